// File: rtl/cache_arbiter_if.sv
// Burst request/data channel between a cache and memory: address phase plus write and read beat handshakes.
// Latency: none, wires only. Backpressure: rw_addr_rdy, w_rdy and r_rdy are driven by the receiving side.
interface cache_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  rw_addr_vld;
    logic                  rw_addr_rdy;
    logic [ADDR_WIDTH-1:0] rw_addr;
    logic                  rw_we;
    logic [7:0]            rw_len;
    logic [2:0]            rw_size;
    logic [1:0]            rw_burst;
    logic                  rw_if;
    logic                  w_vld;
    logic                  w_rdy;
    logic [DATA_WIDTH-1:0] w_dat;
    logic                  r_vld;
    logic                  r_rdy;
    logic [DATA_WIDTH-1:0] r_dat;

    // master issues bursts, slave serves them
    modport master (
        output rw_addr_vld, rw_addr, rw_we, rw_len, rw_size, rw_burst, rw_if,
        output w_vld, w_dat, r_rdy,
        input  rw_addr_rdy, w_rdy, r_vld, r_dat
    );

    modport slave (
        input  rw_addr_vld, rw_addr, rw_we, rw_len, rw_size, rw_burst, rw_if,
        input  w_vld, w_dat, r_rdy,
        output rw_addr_rdy, w_rdy, r_vld, r_dat
    );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache (s0) and D-cache (s1) bursts onto one memory port; YSYX_22050133_ARB_RR_EN selects round-robin, else s1 wins ties.
// Latency: grant is combinational in IDLE, m address valid the next cycle; data beats pass through with zero latency.
// Backpressure: loser sees rw_addr_rdy low and must hold; beat ready/valid forwarded unregistered between owner and memory.
module cache_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    cache_arbiter_if.slave  s0,
    cache_arbiter_if.slave  s1,
    cache_arbiter_if.master m
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  fetch;
    } req_t;

    state_t     state;
    logic       owner;
    logic       we_q;
    logic [7:0] cnt;
    logic       addr_vld_q;
    req_t       m_req_q;

    logic       any_vld;
    logic       win;
    logic       grant;
    req_t       win_req;
    logic       wr_act;
    logic       rd_act;
    logic       beat;

`ifdef YSYX_22050133_ARB_RR_EN
    logic       rr_pref;

    always_comb begin
        win = s1.rw_addr_vld;
        if (s0.rw_addr_vld && s1.rw_addr_vld)
            win = rr_pref;
    end
`else
    always_comb begin
        win = s1.rw_addr_vld;
    end
`endif

    // gating with rst keeps every output low while reset is held
    assign any_vld = s0.rw_addr_vld | s1.rw_addr_vld;
    assign grant   = rst && (state == IDLE) && any_vld;

    assign s0.rw_addr_rdy = grant & ~win;
    assign s1.rw_addr_rdy = grant &  win;

    always_comb begin
        if (win)
            win_req = '{addr: s1.rw_addr, we: s1.rw_we, len: s1.rw_len,
                        size: s1.rw_size, burst: s1.rw_burst, fetch: s1.rw_if};
        else
            win_req = '{addr: s0.rw_addr, we: s0.rw_we, len: s0.rw_len,
                        size: s0.rw_size, burst: s0.rw_burst, fetch: s0.rw_if};
    end

    assign m.rw_addr_vld = addr_vld_q;
    assign m.rw_addr     = m_req_q.addr;
    assign m.rw_we       = m_req_q.we;
    assign m.rw_len      = m_req_q.len;
    assign m.rw_size     = m_req_q.size;
    assign m.rw_burst    = m_req_q.burst;
    assign m.rw_if       = m_req_q.fetch;

    assign wr_act = (state == DATA) &&  we_q;
    assign rd_act = (state == DATA) && !we_q;

    assign m.w_vld  = wr_act & (owner ? s1.w_vld : s0.w_vld);
    assign m.w_dat  = wr_act ? (owner ? s1.w_dat : s0.w_dat) : '0;
    assign s0.w_rdy = wr_act & ~owner & m.w_rdy;
    assign s1.w_rdy = wr_act &  owner & m.w_rdy;

    assign m.r_rdy  = rd_act & (owner ? s1.r_rdy : s0.r_rdy);
    assign s0.r_vld = rd_act & ~owner & m.r_vld;
    assign s1.r_vld = rd_act &  owner & m.r_vld;
    assign s0.r_dat = (rd_act && !owner) ? m.r_dat : '0;
    assign s1.r_dat = (rd_act &&  owner) ? m.r_dat : '0;

    assign beat = wr_act ? (m.w_vld & m.w_rdy) : (m.r_vld & m.r_rdy & rd_act);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            cnt        <= 8'd0;
            addr_vld_q <= 1'b0;
            m_req_q    <= '0;
`ifdef YSYX_22050133_ARB_RR_EN
            rr_pref    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner      <= win;
                        we_q       <= win_req.we;
                        m_req_q    <= win_req;
                        addr_vld_q <= 1'b1;
                        state      <= ADDR;
`ifdef YSYX_22050133_ARB_RR_EN
                        rr_pref    <= ~win;
`endif
                    end
                end
                ADDR: begin
                    if (m.rw_addr_rdy) begin
                        addr_vld_q <= 1'b0;
                        m_req_q    <= '0;
                        cnt        <= m_req_q.len;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    // counter holds beats remaining after the current one
                    if (beat) begin
                        if (cnt == 8'd0)
                            state <= IDLE;
                        else
                            cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed-plus-random bench for cache_arbiter: a queue-based memory/requester model checks grants, beat order and isolation.
module tb_cache_arbiter;
    logic clk;
    logic rst;

    cache_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) s0_if ();
    cache_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) s1_if ();
    cache_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) m_if ();

    cache_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .s0  (s0_if),
        .s1  (s1_if),
        .m   (m_if)
    );

    logic [1:0]       req_vld;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_we;
    logic [1:0][7:0]  req_len;
    logic [1:0][2:0]  req_size;
    logic [1:0][1:0]  req_burst;
    logic [1:0]       req_if;
    logic [1:0]       wv;
    logic [1:0][63:0] wd;
    logic [1:0]       rr;
    logic             mem_addr_rdy;
    logic             mem_w_rdy;
    logic             mem_r_vld;
    logic [63:0]      mem_r_dat;

    wire  [1:0]       arr;
    wire  [1:0]       wr;
    wire  [1:0]       rv;
    wire  [1:0][63:0] rd;

    assign s0_if.rw_addr_vld = req_vld[0];
    assign s0_if.rw_addr     = req_addr[0];
    assign s0_if.rw_we       = req_we[0];
    assign s0_if.rw_len      = req_len[0];
    assign s0_if.rw_size     = req_size[0];
    assign s0_if.rw_burst    = req_burst[0];
    assign s0_if.rw_if       = req_if[0];
    assign s0_if.w_vld       = wv[0];
    assign s0_if.w_dat       = wd[0];
    assign s0_if.r_rdy       = rr[0];
    assign s1_if.rw_addr_vld = req_vld[1];
    assign s1_if.rw_addr     = req_addr[1];
    assign s1_if.rw_we       = req_we[1];
    assign s1_if.rw_len      = req_len[1];
    assign s1_if.rw_size     = req_size[1];
    assign s1_if.rw_burst    = req_burst[1];
    assign s1_if.rw_if       = req_if[1];
    assign s1_if.w_vld       = wv[1];
    assign s1_if.w_dat       = wd[1];
    assign s1_if.r_rdy       = rr[1];
    assign arr[0] = s0_if.rw_addr_rdy;
    assign arr[1] = s1_if.rw_addr_rdy;
    assign wr[0]  = s0_if.w_rdy;
    assign wr[1]  = s1_if.w_rdy;
    assign rv[0]  = s0_if.r_vld;
    assign rv[1]  = s1_if.r_vld;
    assign rd[0]  = s0_if.r_dat;
    assign rd[1]  = s1_if.r_dat;
    assign m_if.rw_addr_rdy = mem_addr_rdy;
    assign m_if.w_rdy       = mem_w_rdy;
    assign m_if.r_vld       = mem_r_vld;
    assign m_if.r_dat       = mem_r_dat;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_grant;
    int last_hs_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        any_out = (|arr) | (|wr) | (|rv) | (|rd) | m_if.rw_addr_vld | (|m_if.rw_addr) |
                  m_if.rw_we | (|m_if.rw_len) | (|m_if.rw_size) | (|m_if.rw_burst) |
                  m_if.rw_if | m_if.w_vld | (|m_if.w_dat) | m_if.r_rdy;
    endfunction

    task automatic clear_inputs();
        req_vld = '0; req_addr = '0; req_we = '0; req_len = '0; req_size = '0;
        req_burst = '0; req_if = '0; wv = '0; wd = '0; rr = '0;
        mem_addr_rdy = 1'b0; mem_w_rdy = 1'b0; mem_r_vld = 1'b0; mem_r_dat = '0;
    endtask

    // Called just after a negedge; grant must be visible in this same cycle.
    task automatic wait_grant(input int port, input string tag);
        int waited = 0;
        #1;
        while (!arr[port] && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        chk({tag, "_grant"}, 64'(arr[port]), 64'd1);
        chk({tag, "_grant_latency"}, 64'(waited), 64'd0);
        chk({tag, "_grant_excl"}, 64'(arr[1-port]), 64'd0);
        if (arr[port]) last_grant = port;
    endtask

    // mode 0: all ready/valid, 1: random, 2: memory ready toggles each cycle
    task automatic run_burst(input int port, input logic we, input logic [31:0] addr,
                             input int len, input int mode, input string tag);
        logic [63:0] q[$];
        int n, idx, err, budget, other;
        logic clean, stable;
        other = 1 - port;
        n = len + 1;
        for (int i = 0; i < n; i++)
            q.push_back(mode == 1 ? {$urandom, $urandom} : 64'((i + 1) * 17));
        req_addr[port] = addr; req_we[port] = we; req_len[port] = 8'(len);
        req_size[port] = 3'd3; req_burst[port] = 2'd1; req_if[port] = (port == 0);
        req_vld[port] = 1'b1;
        wait_grant(port, tag);
        @(negedge clk);
        req_vld[port] = 1'b0;
        mem_addr_rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk({tag, "_m_addr_vld"}, 64'(m_if.rw_addr_vld), 64'd1);
        chk({tag, "_m_addr"}, 64'(m_if.rw_addr), 64'(addr));
        chk({tag, "_m_we"}, 64'(m_if.rw_we), 64'(we));
        chk({tag, "_m_len"}, 64'(m_if.rw_len), 64'(len));
        stable = 1'b1;
        budget = 0;
        while (!mem_addr_rdy && budget < 50) begin
            @(negedge clk);
            mem_addr_rdy = 1'($urandom_range(0, 1));
            budget++;
            #1;
            if (!(m_if.rw_addr_vld === 1'b1 && m_if.rw_addr === addr)) stable = 1'b0;
        end
        chk({tag, "_addr_stable"}, 64'(stable), 64'd1);
        last_hs_cyc = cyc;
        @(negedge clk);
        mem_addr_rdy = 1'b0;
        #1;
        chk({tag, "_addr_vld_clear"}, 64'(m_if.rw_addr_vld), 64'd0);
        idx = 0; err = 0; budget = 0; clean = 1'b1;
        while (idx < n && budget < 5000) begin
            wv[other] = 1'($urandom_range(0, 1));
            wd[other] = {$urandom, $urandom};
            rr[other] = 1'($urandom_range(0, 1));
            if (we) begin
                wv[port]  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                wd[port]  = q[idx];
                mem_w_rdy = (mode == 1) ? 1'($urandom_range(0, 1)) :
                            (mode == 2) ? ~mem_w_rdy : 1'b1;
                #1;
                if (m_if.w_vld !== wv[port]) err++;
                if (wv[port] && mem_w_rdy) begin
                    if (!(m_if.w_dat === q[idx] && wr[port] === 1'b1)) err++;
                    idx++;
                end
            end else begin
                mem_r_vld = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                mem_r_dat = q[idx];
                rr[port]  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (m_if.r_rdy !== rr[port]) err++;
                if (mem_r_vld && rr[port]) begin
                    if (!(rv[port] === 1'b1 && rd[port] === q[idx])) err++;
                    idx++;
                end
            end
            if (arr[other] || wr[other] || rv[other] || rd[other] != 64'd0) clean = 1'b0;
            @(negedge clk);
            budget++;
        end
        chk({tag, "_beats"}, 64'(idx), 64'(n));
        chk({tag, "_beat_errors"}, 64'(err), 64'd0);
        chk({tag, "_other_port_quiet"}, 64'(clean), 64'd1);
        // keep everything asserted one more cycle: nothing may pass after the last beat
        wv[port] = 1'b1; mem_w_rdy = 1'b1; mem_r_vld = 1'b1; rr[port] = 1'b1;
        #1;
        chk({tag, "_no_extra_beat"}, 64'({m_if.w_vld, rv[port], m_if.r_rdy, wr[port]}), 64'd0);
        wv = '0; wd = '0; rr = '0; mem_w_rdy = 1'b0; mem_r_vld = 1'b0; mem_r_dat = '0;
    endtask

    initial begin
        int hs_wb, w, l;
        logic [31:0] a0, a1;
        logic we0, we1;
        clear_inputs();
        rst = 1'b0;
        last_grant = 1;
        req_vld = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_zero", 64'(any_out()), 64'd0);
        req_vld = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        run_burst(0, 1'b0, 32'h8000_0040, 7, 0, "s0_read");
        run_burst(1, 1'b1, 32'h8000_1000, 7, 2, "s1_write_toggle");

        run_burst(1, 1'b1, 32'h8000_2000, 0, 0, "wb");
        hs_wb = last_hs_cyc;
        run_burst(1, 1'b0, 32'h8000_2000, 0, 0, "refill");
        chk("b2b_hs_gap", 64'(last_hs_cyc - hs_wb), 64'd3);

        // reset in the 4th beat of an 8-beat read
        req_addr[0] = 32'h8000_0100; req_we[0] = 1'b0; req_len[0] = 8'd7; req_vld[0] = 1'b1;
        wait_grant(0, "abort");
        @(negedge clk);
        req_vld[0] = 1'b0; mem_addr_rdy = 1'b1;
        @(negedge clk);
        mem_addr_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_r_vld = 1'b1; rr[0] = 1'b1; mem_r_dat = 64'(i);
            @(negedge clk);
        end
        mem_r_vld = 1'b1; rr[0] = 1'b1; mem_r_dat = 64'hDEAD; req_vld = 2'b11;
        #1;
        chk("abort_beat4_live", 64'(rv[0]), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_async_zero", 64'(any_out()), 64'd0);
        @(negedge clk); #1;
        chk("abort_held_zero", 64'(any_out()), 64'd0);
        clear_inputs();
        rst = 1'b1;
        last_grant = 1;

        // simultaneous requests; loser keeps valid and is served next
        for (int r = 0; r < 4; r++) begin
            a0 = $urandom & 32'hFFFF_FFC0; a1 = $urandom & 32'hFFFF_FFC0;
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            req_addr[0] = a0; req_we[0] = we0; req_len[0] = 8'd3;
            req_addr[1] = a1; req_we[1] = we1; req_len[1] = 8'd3;
            req_vld = 2'b11;
            #1;
`ifdef YSYX_22050133_ARB_RR_EN
            w = 1 - last_grant;
`else
            w = 1;
`endif
            l = 1 - w;
            chk($sformatf("arb%0d_winner", r), 64'(arr[w]), 64'd1);
            chk($sformatf("arb%0d_loser_wait", r), 64'(arr[l]), 64'd0);
            run_burst(w, w ? we1 : we0, w ? a1 : a0, 3, 1, $sformatf("arb%0d_w", r));
            run_burst(l, l ? we1 : we0, l ? a1 : a0, 3, 1, $sformatf("arb%0d_l", r));
        end

        for (int k = 0; k < 6; k++)
            run_burst($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                      $urandom & 32'hFFFF_FFC0, $urandom_range(0, 15), 1,
                      $sformatf("rand%0d", k));

        run_burst(0, 1'b0, 32'h8000_4000, 255, 1, "len255");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
